// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared MMIO map, RAM width default and 7-segment patterns
package dmem_bridge_pkg;

  localparam int RAM_AW_DEFAULT = 14;

  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_F000;
  localparam logic [31:0] DISP_ADDR  = MMIO_BASE + 32'h0000_0000;
  localparam logic [31:0] TIMER_ADDR = MMIO_BASE + 32'h0000_0020;
  localparam logic [31:0] LED_ADDR   = MMIO_BASE + 32'h0000_0060;
  localparam logic [31:0] SW_ADDR    = MMIO_BASE + 32'h0000_0070;

  // Active-low {dp,g,f,e,d,c,b,a}, dp always off.
  localparam logic [7:0] SEG_PAT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] target);
    return a[31:2] == target[31:2];
  endfunction

endpackage

// File: rtl/dmem_bridge_seg7_decode.sv
// rtl/dmem_bridge_seg7_decode.sv - hex nibble to active-low 7-segment pattern
module seg7_decode
  import dmem_bridge_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_PAT[hex];

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - CPU data-port responder: word RAM plus LED/switch/display/timer MMIO
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int RAM_AW    = RAM_AW_DEFAULT,
  parameter int SCAN_DIV  = 50000,
  parameter int TIMER_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [23:0] sw,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int TW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int SW_W = $clog2(SCAN_DIV);

  logic [31:0]     ram [2**RAM_AW];
  logic [31:0]     disp;
  logic [31:0]     timer;
  logic [TW-1:0]   presc;
  logic [SW_W-1:0] scan_cnt;
  logic [2:0]      dig_idx;
  logic [23:0]     sw_s1, sw_s2;
  logic [7:0]      seg_next;
  logic            ram_sel, disp_sel, timer_sel, led_sel, sw_sel;
  logic            tick, scan_tc;
  logic            unused_addr;

  assign unused_addr = ^addr[1:0];

  assign ram_sel   = (addr[31:RAM_AW+2] == '0);
  assign disp_sel  = word_match(addr, DISP_ADDR);
  assign timer_sel = word_match(addr, TIMER_ADDR);
  assign led_sel   = word_match(addr, LED_ADDR);
  assign sw_sel    = word_match(addr, SW_ADDR);

  assign tick    = (presc == TW'(TIMER_DIV - 1));
  assign scan_tc = (scan_cnt == SW_W'(SCAN_DIV - 1));

  always_comb begin
    rdata = '0;
    if (ram_sel)        rdata = ram[addr[RAM_AW+1:2]];
    else if (disp_sel)  rdata = disp;
    else if (timer_sel) rdata = timer;
    else if (led_sel)   rdata = {8'h00, led};
    else if (sw_sel)    rdata = {8'h00, sw_s2};
  end

  // RAM is not reset; gating with rst_n drops a store that coincides with reset.
  always_ff @(posedge clk) begin
    if (we && rst_n && ram_sel) ram[addr[RAM_AW+1:2]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led   <= '0;
      disp  <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (we && led_sel)  led  <= wdata[23:0];
      if (we && disp_sel) disp <= wdata;
    end
  end

  // A store to TIMER overrides a coincident tick and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      presc <= '0;
    end else if (we && timer_sel) begin
      timer <= wdata;
      presc <= '0;
    end else if (tick) begin
      timer <= timer + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + TW'(1);
    end
  end

  seg7_decode u_seg7 (
    .hex (disp[{dig_idx, 2'b00} +: 4]),
    .seg (seg_next)
  );

  // Outputs are registered so digit select and segments switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      dig_en   <= 8'hFE;
      seg      <= SEG_PAT[0];
    end else begin
      if (scan_tc) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SW_W'(1);
      end
      dig_en <= ~(8'd1 << dig_idx);
      seg    <= seg_next;
    end
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side responder for the single-cycle RISC-V core: it receives the core's data address, write data and write strobe, and returns read data in the same cycle. It decodes the address into a word RAM and a small MMIO page (LEDs, switches, 7-segment display, free-running timer), and owns all sequential state behind those addresses. It sits between the CPU data port and the board pins.

## Interface
- RAM_AW, 14, RAM word-address width (RAM = 2^RAM_AW 32-bit words)
- SCAN_DIV, 50000, clk cycles each 7-segment digit stays selected (≥2)
- TIMER_DIV, 1, clk cycles per timer increment (≥1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  32  data byte address from CPU ALU result
- wdata  in  32  store data (CPU rs2)
- we  in  1  store strobe (CPU mem_write)
- rdata  out  32  load data, combinational from addr
- sw  in  24  raw board switches (asynchronous)
- led  out  24  LED register
- dig_en  out  8  digit selects, active-low, exactly one low
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Address decode uses addr[31:2]; addr[1:0] ignored (word accesses only).
- RAM: addr < 4·2^RAM_AW; index addr[RAM_AW+1:2].
- MMIO (full 32-bit match on addr[31:2]):
  - 0xFFFF_F000 DISP: 32-bit display value, R/W
  - 0xFFFF_F020 TIMER: counter, R/W (write loads)
  - 0xFFFF_F060 LED: R/W, bits [23:0] used, reads zero-extended
  - 0xFFFF_F070 SW: read-only synchronized switches, zero-extended; writes ignored
- Any other address: read 0, write ignored.
- Switch sync: two flops; rdata reflects sw two rising edges after change.
- Timer: prescaler counts 0..TIMER_DIV-1; on terminal count TIMER += 1, wraps 0xFFFF_FFFF→0. Write to TIMER on same edge as tick: write value wins, prescaler resets to 0.
- Display scanner: divider 0..SCAN_DIV-1; on terminal count digit index 0..7 advances, 7→0. dig_en[i]=0 iff index==i. seg = hex pattern of DISP[4i+3:4i], dp off (1).

## Timing
- Reads: zero-cycle, purely combinational from addr and current state.
- Writes: take effect on the rising edge where we=1; a read of the same address in that cycle returns the old value; the next cycle sees the new one.
- Reset values: led=0, DISP=0, TIMER=0, both prescalers=0, sync flops=0, digit index=0 so dig_en=8'hFE, seg=pattern of 0 (8'hC0). RAM contents are not reset (initialised from image at elaboration only).
- Reset mid-operation: all registers above return to reset values asynchronously; a we pulse coincident with reset is lost.
- seg/dig_en registered off index and DISP: change one cycle after DISP write or index advance; no glitch between digits.

## Structure
- Shared package: MMIO base/offset constants (DISP, TIMER, LED, SW), RAM_AW default, 7-segment active-low patterns 0–F.
- One sub-module seg7_decode (4-bit hex → 8-bit active-low segments), combinational.
- RAM inferred as distributed/async-read memory in-block; no separate module.

## Test plan
- Reset: assert rst_n=0 mid-run → led=0, dig_en=8'hFE, seg=8'hC0, TIMER read 0.
- RAM: write 0xDEAD_BEEF to 0x0000_0010 (we=1 one cycle) → same-cycle read old value, next cycle read 0xDEAD_BEEF; read 0x0000_0013 also returns it.
- MMIO: write 0x00AB_CDEF to 0xFFFF_F060 → led=24'hABCDEF; write 0x1234 to 0xFFFF_F070 → SW read unchanged; read 0xFFFF_F100 → 0.
- Switches: sw 0→0x00_00FF → SW read 0 for two edges, 0x0000_00FF on third cycle.
- Timer (TIMER_DIV=1): write 0xFFFF_FFFE, wait 2 cycles → 0x0000_0000; write 5 on a tick edge → reads 5, then 6.
- Scanner (SCAN_DIV=2): DISP=0x8765_4321 → dig_en steps FE,FD,…,7F,FE every 2 cycles; seg 0xF9 (1) at FE, 0x80 (8) at 7F.
